// File: rtl/rom_loader.sv
// rom_loader
//   Writer side of the instruction ROM write port. Parses a 4-byte
//   little-endian word-count header from a byte stream, then assembles
//   little-endian 32-bit words and issues one single-cycle ROM write per
//   word. The core is held in reset while an image is loading and is only
//   released after a complete, valid image.
//
// Optional feature: define ROM_LOADER_CHECKSUM_EN to require a trailing
//   checksum byte c such that (sum of payload bytes + c) mod 256 == 0.
//
// Ports:
//   clk_i         clock
//   rst_n_i       asynchronous active-low reset
//   start_i       single-cycle pulse that begins a load (ignored while busy)
//   byte_valid_i  byte_data_i is valid
//   byte_data_i   stream byte
//   byte_ready_o  loader accepts a byte this cycle
//   rom_wen_o     ROM write enable, one-cycle pulse per word
//   rom_waddr_o   ROM byte address (word-aligned), held between writes
//   rom_wdata_o   ROM write data, held between writes
//   busy_o        load in progress
//   done_o        last load completed successfully
//   err_o         last load failed
//   core_rst_n_o  active-low reset to the core

module rom_loader #(
  parameter int          ROM_DEPTH = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        rom_wen_o,
  output logic [31:0] rom_waddr_o,
  output logic [31:0] rom_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        core_rst_n_o
);

  localparam logic [31:0] LP_DEPTH = 32'(ROM_DEPTH);

  // S_LAST is the cycle carrying the final write pulse; it keeps DONE/CHK
  // one cycle behind that pulse and stops byte acceptance meanwhile.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_LAST,
`ifdef ROM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_byte_ready;
  logic        r_wen;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_core_rst_n;

  logic [1:0]  r_bcnt;
  logic [23:0] r_buf;
  logic [31:0] r_count;
  logic [31:0] r_widx;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]  r_sum;
  logic        w_sum_ok;
`endif

  logic        w_ready_nxt;
  logic        w_wen_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic        w_core_nxt;
  logic        w_clear;
  logic        w_accept;
  logic        w_last_byte;
  logic        w_last_word;
  logic [31:0] w_word;

  assign w_accept    = byte_valid_i && r_byte_ready;
  assign w_last_byte = w_accept && (r_bcnt == 2'd3);
  // r_buf holds the three earlier bytes; the incoming byte is the MSB.
  assign w_word      = {byte_data_i, r_buf};
  assign w_last_word = ((r_widx + 32'd1) == r_count);
`ifdef ROM_LOADER_CHECKSUM_EN
  assign w_sum_ok    = (8'(r_sum + byte_data_i) == 8'h00);
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = 1'b0;
    w_wen_nxt   = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_core_nxt  = r_core_rst_n;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (r_state == S_IDLE) begin
          w_core_nxt = 1'b1;
        end
        if (start_i) begin
          w_state_nxt = S_LEN;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_err_nxt   = 1'b0;
          w_core_nxt  = 1'b0;
          w_clear     = 1'b1;
        end
      end
      S_LEN: begin
        w_ready_nxt = 1'b1;
        if (w_last_byte) begin
          if ((w_word == 32'd0) || (w_word > LP_DEPTH)) begin
            w_state_nxt = S_ERR;
            w_ready_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        w_ready_nxt = 1'b1;
        if (w_last_byte) begin
          w_wen_nxt = 1'b1;
          if (w_last_word) begin
            w_state_nxt = S_LAST;
            w_ready_nxt = 1'b0;
          end
        end
      end
      S_LAST: begin
`ifdef ROM_LOADER_CHECKSUM_EN
        w_state_nxt = S_CHK;
        w_ready_nxt = 1'b1;
`else
        w_state_nxt = S_DONE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_core_nxt  = 1'b1;
`endif
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CHK: begin
        w_ready_nxt = 1'b1;
        if (w_accept) begin
          w_ready_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          if (w_sum_ok) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_core_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_ERR;
            w_err_nxt   = 1'b1;
          end
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered control outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b0;
      r_wen        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_byte_ready <= w_ready_nxt;
      r_wen        <= w_wen_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_core_rst_n <= w_core_nxt;
    end
  end

  // Byte assembly, header capture and ROM address/data. Address and data
  // only change on a completed word, so they hold between write pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_bcnt  <= 2'd0;
      r_buf   <= 24'd0;
      r_count <= 32'd0;
      r_widx  <= 32'd0;
      r_waddr <= 32'd0;
      r_wdata <= 32'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
      r_sum   <= 8'd0;
`endif
    end else if (w_clear) begin
      r_bcnt  <= 2'd0;
      r_buf   <= 24'd0;
      r_widx  <= 32'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
      r_sum   <= 8'd0;
`endif
    end else if (w_accept && ((r_state == S_LEN) || (r_state == S_DATA))) begin
      r_bcnt <= r_bcnt + 2'd1;
      r_buf  <= {byte_data_i, r_buf[23:8]};
      if (r_bcnt == 2'd3) begin
        if (r_state == S_LEN) begin
          r_count <= w_word;
        end else begin
          r_waddr <= BASE_ADDR + (r_widx << 2);
          r_wdata <= w_word;
          r_widx  <= r_widx + 32'd1;
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      if (r_state == S_DATA) begin
        r_sum <= r_sum + byte_data_i;
      end
`endif
    end
  end

  assign byte_ready_o = r_byte_ready;
  assign rom_wen_o    = r_wen;
  assign rom_waddr_o  = r_waddr;
  assign rom_wdata_o  = r_wdata;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign core_rst_n_o = r_core_rst_n;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader
//   Directed testbench for rom_loader. Inputs are driven on the falling
//   clock edge and outputs are sampled there, away from the active edge.
//   Checksum cases are built only when ROM_LOADER_CHECKSUM_EN is defined.

module tb_rom_loader;

  localparam logic [31:0] TB_BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic        byteValid = 1'b0;
  logic [7:0]  byteData = 8'h00;
  logic        byteReady;
  logic        romWen;
  logic [31:0] romWaddr;
  logic [31:0] romWdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        coreRstN;

  int total = 0;
  int bad = 0;

  int          wrCount = 0;
  int          coreBad = 0;
  logic [31:0] wrAddr [0:63];
  logic [31:0] wrData [0:63];

  always #5 clk = ~clk;

  rom_loader #(
    .ROM_DEPTH(4096),
    .BASE_ADDR(TB_BASE)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rstN),
    .start_i      (start),
    .byte_valid_i (byteValid),
    .byte_data_i  (byteData),
    .byte_ready_o (byteReady),
    .rom_wen_o    (romWen),
    .rom_waddr_o  (romWaddr),
    .rom_wdata_o  (romWdata),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .core_rst_n_o (coreRstN)
  );

  // Log every ROM write pulse and any cycle where the core is out of reset
  // while a load is in progress.
  always @(negedge clk) begin
    if (romWen) begin
      if (wrCount < 64) begin
        wrAddr[wrCount] <= romWaddr;
        wrData[wrCount] <= romWdata;
      end
      wrCount <= wrCount + 1;
    end
    if (busy && coreRstN) begin
      coreBad <= coreBad + 1;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  // Entered and left on a falling edge.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int guard;
    byteValid = 1'b0;
    repeat (gap) @(negedge clk);
    byteValid = 1'b1;
    byteData  = b;
    guard = 0;
    while (!byteReady && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      checkOutput("readyWait", {31'd0, byteReady}, 32'd1);
    end
    @(negedge clk);
    byteValid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int maxGap);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(w[8*i +: 8], (maxGap == 0) ? 0 : int'($urandom_range(maxGap, 0)));
    end
  endtask

  task automatic startLoad();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkWrite(input int idx, input logic [31:0] addr, input logic [31:0] data);
    checkOutput("wrAddr", wrAddr[idx], addr);
    checkOutput("wrData", wrData[idx], data);
  endtask

  task automatic checkResetValues();
    checkOutput("rstReady", {31'd0, byteReady}, 32'd0);
    checkOutput("rstWen",   {31'd0, romWen},    32'd0);
    checkOutput("rstWaddr", romWaddr,           32'd0);
    checkOutput("rstWdata", romWdata,           32'd0);
    checkOutput("rstBusy",  {31'd0, busy},      32'd0);
    checkOutput("rstDone",  {31'd0, done},      32'd0);
    checkOutput("rstErr",   {31'd0, err},       32'd0);
    checkOutput("rstCore",  {31'd0, coreRstN},  32'd0);
  endtask

  initial begin
    int base;
    int cb;

    // Reset values, then core released on the first edge in IDLE.
    rstN = 1'b0;
    idle(3);
    checkResetValues();
    rstN = 1'b1;
    idle(1);
    checkOutput("idleCore", {31'd0, coreRstN}, 32'd1);
    checkOutput("idleBusy", {31'd0, busy},     32'd0);

    // Single word load.
    base = wrCount;
    startLoad();
    checkOutput("t1Busy",  {31'd0, busy},      32'd1);
    checkOutput("t1Core",  {31'd0, coreRstN},  32'd0);
    checkOutput("t1Ready", {31'd0, byteReady}, 32'd1);
    sendWord(32'd1, 0);
    sendWord(32'h1234_5678, 0);
    idle(3);
    checkOutput("t1Writes", wrCount - base, 32'd1);
    checkWrite(base, TB_BASE, 32'h1234_5678);
    checkOutput("t1Done",  {31'd0, done},      32'd1);
    checkOutput("t1Err",   {31'd0, err},       32'd0);
    checkOutput("t1CoreD", {31'd0, coreRstN},  32'd1);
    checkOutput("t1BusyD", {31'd0, busy},      32'd0);
    checkOutput("t1RdyD",  {31'd0, byteReady}, 32'd0);
    checkOutput("t1Hold",  romWaddr,           TB_BASE);

    // Three words back to back.
    base = wrCount;
    cb = coreBad;
    startLoad();
    checkOutput("t2DoneClr", {31'd0, done}, 32'd0);
    sendWord(32'd3, 0);
    sendWord(32'hAABB_CCDD, 0);
    sendWord(32'hDEAD_BEEF, 0);
    sendWord(32'h1122_3344, 0);
    idle(3);
    checkOutput("t2Writes", wrCount - base, 32'd3);
    checkWrite(base,     TB_BASE,         32'hAABB_CCDD);
    checkWrite(base + 1, TB_BASE + 32'd4, 32'hDEAD_BEEF);
    checkWrite(base + 2, TB_BASE + 32'd8, 32'h1122_3344);
    checkOutput("t2CoreHeld", coreBad - cb, 32'd0);
    checkOutput("t2Done", {31'd0, done}, 32'd1);

    // Illegal word counts: zero and ROM_DEPTH+1.
    base = wrCount;
    startLoad();
    sendWord(32'd0, 0);
    idle(2);
    checkOutput("t3ErrZero",  {31'd0, err},       32'd1);
    checkOutput("t3BusyZero", {31'd0, busy},      32'd0);
    checkOutput("t3CoreZero", {31'd0, coreRstN},  32'd0);
    checkOutput("t3RdyZero",  {31'd0, byteReady}, 32'd0);
    checkOutput("t3DoneZero", {31'd0, done},      32'd0);
    startLoad();
    checkOutput("t3ErrClr1", {31'd0, err}, 32'd0);
    sendWord(32'd4097, 0);
    idle(2);
    checkOutput("t3ErrBig",  {31'd0, err},      32'd1);
    checkOutput("t3CoreBig", {31'd0, coreRstN}, 32'd0);
    checkOutput("t3Writes",  wrCount - base,    32'd0);
    startLoad();
    checkOutput("t3ErrClr2", {31'd0, err},  32'd0);
    checkOutput("t3Busy2",   {31'd0, busy}, 32'd1);
    // Exactly ROM_DEPTH is legal: loader must move on to payload.
    sendWord(32'd4096, 0);
    idle(2);
    checkOutput("t3MaxErr",  {31'd0, err},       32'd0);
    checkOutput("t3MaxBusy", {31'd0, busy},      32'd1);
    checkOutput("t3MaxRdy",  {31'd0, byteReady}, 32'd1);
    rstN = 1'b0;
    idle(1);
    rstN = 1'b1;
    idle(1);

    // Two words with random gaps and a start pulse mid-load.
    base = wrCount;
    startLoad();
    sendWord(32'd2, 7);
    applyStimulus(8'h0D, int'($urandom_range(7, 0)));
    applyStimulus(8'hF0, int'($urandom_range(7, 0)));
    startLoad();
    checkOutput("t4BusyMid", {31'd0, busy}, 32'd1);
    checkOutput("t4DoneMid", {31'd0, done}, 32'd0);
    applyStimulus(8'hFE, int'($urandom_range(7, 0)));
    applyStimulus(8'hCA, int'($urandom_range(7, 0)));
    sendWord(32'h0123_4567, 7);
    idle(3);
    checkOutput("t4Writes", wrCount - base, 32'd2);
    checkWrite(base,     TB_BASE,         32'hCAFE_F00D);
    checkWrite(base + 1, TB_BASE + 32'd4, 32'h0123_4567);
    checkOutput("t4Done", {31'd0, done}, 32'd1);

    // Reset after 1.5 words of a 4-word image.
    base = wrCount;
    startLoad();
    sendWord(32'd4, 0);
    sendWord(32'h55AA_33CC, 0);
    applyStimulus(8'h10, 1);
    applyStimulus(8'h20, 2);
    #2;
    rstN = 1'b0;
    #1;
    checkResetValues();
    checkOutput("t5Writes", wrCount - base, 32'd1);
    checkWrite(base, TB_BASE, 32'h55AA_33CC);
    @(negedge clk);
    rstN = 1'b1;
    byteValid = 1'b1;
    byteData  = 8'h77;
    idle(8);
    byteValid = 1'b0;
    checkOutput("t5NoMore", wrCount - base,       32'd1);
    checkOutput("t5Busy",   {31'd0, busy},        32'd0);
    checkOutput("t5Core",   {31'd0, coreRstN},    32'd1);
    checkOutput("t5Ready",  {31'd0, byteReady},   32'd0);

`ifdef ROM_LOADER_CHECKSUM_EN
    // Checksum accepted: 01+02+03+04+F6 = 0x100.
    base = wrCount;
    startLoad();
    sendWord(32'd1, 0);
    sendWord(32'h0403_0201, 0);
    applyStimulus(8'hF6, 0);
    idle(2);
    checkOutput("c1Done", {31'd0, done},     32'd1);
    checkOutput("c1Err",  {31'd0, err},      32'd0);
    checkOutput("c1Core", {31'd0, coreRstN}, 32'd1);
    checkOutput("c1Writes", wrCount - base,  32'd1);
    checkWrite(base, TB_BASE, 32'h0403_0201);

    // Checksum rejected.
    base = wrCount;
    startLoad();
    sendWord(32'd1, 0);
    sendWord(32'h0403_0201, 0);
    applyStimulus(8'hF7, 0);
    idle(2);
    checkOutput("c2Done", {31'd0, done},     32'd0);
    checkOutput("c2Err",  {31'd0, err},      32'd1);
    checkOutput("c2Core", {31'd0, coreRstN}, 32'd0);
    checkOutput("c2Writes", wrCount - base,  32'd1);
    checkWrite(base, TB_BASE, 32'h0403_0201);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
